// File: rtl/map_rom_server_pkg.sv
// Shared definitions for the map-cell server: cell encodings, default map
// geometry and the init LFSR feedback polynomial.
package map_rom_server_pkg;

  localparam int MAP_WBITS_DEF = 4;
  localparam int MAP_HBITS_DEF = 4;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY  = 2'd0;
  localparam cell_t CELL_BLUE   = 2'd1;
  localparam cell_t CELL_YELLOW = 2'd2;
  localparam cell_t CELL_RED    = 2'd3;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One step of the right-shifting Galois LFSR: lsb falls out, taps fold back in.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/map_init_lfsr.sv
// 8-bit Galois LFSR used to scatter interior blocks while the map is built.
// load reseeds (and wins over step); step advances one position.
module map_init_lfsr
  import map_rom_server_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       load,
  input  logic       step,
  output logic [7:0] state
);

  // Seed on load, otherwise advance when asked.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of statement order.
    if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/map_rom_server.sv
// Map-cell responder: holds the map in flops, fills it after reset with
// border walls plus pseudo-random interior blocks, then serves a
// combinational overlay port, a registered tracer port and a write port.
module map_rom_server
  import map_rom_server_pkg::*;
#(
  parameter int         MAP_WBITS = MAP_WBITS_DEF,
  parameter int         MAP_HBITS = MAP_HBITS_DEF,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [MAP_WBITS-1:0] i_ov_col,
  input  logic [MAP_HBITS-1:0] i_ov_row,
  output logic [1:0]           o_ov_val,
  input  logic                 i_tr_req,
  input  logic [MAP_WBITS-1:0] i_tr_col,
  input  logic [MAP_HBITS-1:0] i_tr_row,
  output logic                 o_tr_valid,
  output logic [1:0]           o_tr_val,
  input  logic                 i_wr_en,
  input  logic [MAP_WBITS-1:0] i_wr_col,
  input  logic [MAP_HBITS-1:0] i_wr_row,
  input  logic [1:0]           i_wr_val,
  output logic                 o_ready
);

  localparam int IBITS = MAP_WBITS + MAP_HBITS;
  localparam int CELLS = 1 << IBITS;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]           state_q;
  logic [IBITS-1:0]     cnt_q;
  logic [7:0]           lfsr;
  cell_t                map_q [CELLS];
  logic                 in_init;
  logic [MAP_WBITS-1:0] init_col;
  logic [MAP_HBITS-1:0] init_row;
  logic                 on_border;
  cell_t                init_val;

  assign in_init  = (state_q == ST_INIT);
  assign o_ready  = (state_q == ST_READY);
  // Raster order with col fastest: the counter is simply {row, col}.
  assign init_col = cnt_q[MAP_WBITS-1:0];
  assign init_row = cnt_q[IBITS-1:MAP_WBITS];

  assign on_border = (init_col == '0) || (init_col == {MAP_WBITS{1'b1}}) ||
                     (init_row == '0) || (init_row == {MAP_HBITS{1'b1}});

  // Pick the value for the cell currently being initialised.
  always_comb begin
    // NOTE: default first so every path assigns init_val and no latch is inferred.
    init_val = CELL_EMPTY;
    if (on_border) begin
      init_val = CELL_BLUE;
    end else if (lfsr[7:6] == 2'b00) begin
      init_val = lfsr[1:0];
    end
  end

  // Reseed in reset, advance once per INIT cycle after its value is used.
  map_init_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .load  (!reset_n),
    .step  (reset_n && in_init),
    .state (lfsr)
  );

  // Init sequencer: walk every cell once, then park in READY until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else if (in_init) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == {IBITS{1'b1}}) begin
        state_q <= ST_READY;
      end
    end
  end

  // Map storage: filled by the sequencer during INIT, edited by writes after.
  always_ff @(posedge clk) begin
    // NOTE: the map array has no reset; INIT rewrites every cell, so
    // resetting it would only add a wide reset fan-out for nothing.
    if (reset_n) begin
      if (in_init) begin
        map_q[cnt_q] <= init_val;
      end else if (i_wr_en) begin
        map_q[{i_wr_row, i_wr_col}] <= i_wr_val;
      end
    end
  end

  // Tracer response: one registered beat per request; reads see the pre-edge
  // map, so a same-edge write returns the old value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_tr_valid <= 1'b0;
      o_tr_val   <= CELL_EMPTY;
    end else begin
      o_tr_valid <= o_ready && i_tr_req;
      if (o_ready && i_tr_req) begin
        o_tr_val <= map_q[{i_tr_row, i_tr_col}];
      end
    end
  end

  // Overlay read is combinational and blanked while the map is being built.
  assign o_ov_val = in_init ? CELL_EMPTY : map_q[{i_ov_row, i_ov_col}];

endmodule

// File: tb/tb_map_rom_server.sv
// Self-checking bench for map_rom_server: reference map model, init latency,
// overlay sweep, tracer scoreboard, read-before-write and reset restart.
module tb_map_rom_server;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ov_col, ov_row, tr_col, tr_row, wr_col, wr_row;
  logic [1:0] ov_val, tr_val, wr_val;
  logic       tr_req, tr_valid, wr_en, ready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  logic [1:0] exp_map [256];

  typedef struct {
    logic [1:0] val;
    int         cyc;
    string      tag;
  } tr_exp_t;
  tr_exp_t sb_q [$];

  map_rom_server dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_ov_col   (ov_col),
    .i_ov_row   (ov_row),
    .o_ov_val   (ov_val),
    .i_tr_req   (tr_req),
    .i_tr_col   (tr_col),
    .i_tr_row   (tr_row),
    .o_tr_valid (tr_valid),
    .o_tr_val   (tr_val),
    .i_wr_en    (wr_en),
    .i_wr_col   (wr_col),
    .i_wr_row   (wr_row),
    .i_wr_val   (wr_val),
    .o_ready    (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference map: border walls, LFSR-scattered interior, seed A5.
  task automatic build_model();
    logic [7:0] s;
    int c, r;
    s = 8'hA5;
    for (int idx = 0; idx < 256; idx++) begin
      c = idx % 16;
      r = idx / 16;
      if (c == 0 || c == 15 || r == 0 || r == 15) exp_map[idx] = 2'd1;
      else if (s[7:6] == 2'b00)                   exp_map[idx] = s[1:0];
      else                                        exp_map[idx] = 2'd0;
      s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    end
  endtask

  task automatic push_tr(input string tag, input logic [1:0] v);
    tr_exp_t e;
    e.val = v;
    e.cyc = cyc;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Tracer monitor: a response is due exactly one cycle after each accepted request.
  always @(negedge clk) begin : tr_mon
    bit      exp_v;
    tr_exp_t e;
    if (mon_en) begin
      exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc - 1);
      check("tr_valid", {31'd0, tr_valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = sb_q.pop_front();
        check(e.tag, {30'd0, tr_val}, {30'd0, e.val});
      end
    end
  end

  // Count 256 cycles from reset release; optionally poke the ports during INIT.
  task automatic wait_ready(input string tag, input bit poke);
    bit early;
    early = 0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (poke && i == 10) begin
        tr_req = 1; tr_col = 4'd2; tr_row = 4'd2;
        wr_en = 1; wr_col = 4'd2; wr_row = 4'd2; wr_val = 2'd2;
        ov_col = 4'd2; ov_row = 4'd2;
      end
      if (poke && i == 11) begin
        tr_req = 0; wr_en = 0;
      end
      @(negedge clk);
      if (poke && i == 10) check("init_ov_forced0", {30'd0, ov_val}, 32'd0);
      if (i < 256 && ready) early = 1;
    end
    check({tag, "_ready_early"}, {31'd0, early}, 32'd0);
    check({tag, "_ready_at_256"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        ov_col = 4'(c); ov_row = 4'(r);
        #1;
        check(tag, {30'd0, ov_val}, {30'd0, exp_map[r*16+c]});
      end
    end
  endtask

  task automatic ov_read(input string tag, input int c, input int r, input logic [1:0] exp);
    ov_col = 4'(c); ov_row = 4'(r);
    #1;
    check(tag, {30'd0, ov_val}, {30'd0, exp});
  endtask

  initial begin
    reset_n = 0; tr_req = 0; wr_en = 0;
    ov_col = 0; ov_row = 0; tr_col = 0; tr_row = 0;
    wr_col = 0; wr_row = 0; wr_val = 0;
    build_model();

    // Reset state.
    @(posedge clk); #1;
    mon_en = 1;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_tr_valid", {31'd0, tr_valid}, 32'd0);
    check("rst_tr_val", {30'd0, tr_val}, 32'd0);
    check("rst_ov", {30'd0, ov_val}, 32'd0);
    reset_n = 1;

    // Init with tracer/write pokes that must be ignored.
    wait_ready("init1", 1'b1);
    ov_read("corner_0_0", 0, 0, 2'd1);
    ov_read("corner_15_0", 15, 0, 2'd1);
    ov_read("corner_0_15", 0, 15, 2'd1);
    ov_read("corner_15_15", 15, 15, 2'd1);
    ov_read("init_wr_ignored", 2, 2, exp_map[2*16+2]);
    sweep("ov_sweep1");

    // Back-to-back tracer reads.
    @(posedge clk); #1;
    tr_req = 1; tr_col = 4'd5; tr_row = 4'd7;
    push_tr("tr_5_7", exp_map[7*16+5]);
    @(posedge clk); #1;
    tr_col = 4'd0; tr_row = 4'd3;
    push_tr("tr_0_3", 2'd1);
    @(posedge clk); #1;
    tr_req = 0;
    repeat (2) @(posedge clk);

    // Write with a same-edge tracer read of the same cell.
    #1;
    wr_en = 1; wr_col = 4'd4; wr_row = 4'd4; wr_val = 2'd3;
    tr_req = 1; tr_col = 4'd4; tr_row = 4'd4;
    ov_col = 4'd4; ov_row = 4'd4;
    push_tr("tr_rbw_old", exp_map[4*16+4]);
    @(negedge clk);
    check("ov_before_wr", {30'd0, ov_val}, {30'd0, exp_map[4*16+4]});
    @(posedge clk); #1;
    wr_en = 0;
    exp_map[4*16+4] = 2'd3;
    push_tr("tr_rbw_new", 2'd3);
    @(negedge clk);
    check("ov_after_wr", {30'd0, ov_val}, 32'd3);
    @(posedge clk); #1;
    tr_req = 0;
    repeat (2) @(posedge clk);

    // Reset from READY with a request in the reset cycle: response dropped.
    #1;
    reset_n = 0; tr_req = 1; tr_col = 4'd1; tr_row = 4'd1;
    @(posedge clk); #1;
    reset_n = 1; tr_req = 0;
    @(negedge clk);
    check("rst2_ready", {31'd0, ready}, 32'd0);

    // Interrupt INIT at cycle 100 with a one-cycle reset.
    for (int i = 1; i < 100; i++) @(posedge clk);
    #1;
    reset_n = 0;
    @(negedge clk);
    check("mid_init_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    check("mid_init_rst_ready", {31'd0, ready}, 32'd0);
    // Release happened just before this cycle's edge count starts.
    reset_n = 1;
    wait_ready("init2", 1'b0);
    build_model();
    sweep("ov_sweep2");

    // One more tracer read after the restart.
    @(posedge clk); #1;
    tr_req = 1; tr_col = 4'd4; tr_row = 4'd4;
    push_tr("tr_after_restart", exp_map[4*16+4]);
    @(posedge clk); #1;
    tr_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
